// File: rtl/synth_cfg_pkg.sv
// synth_cfg_pkg: shared constants and types for the synthesizer configuration
// controller.
//   - MMIO word-index map (ADDR_*)
//   - default field widths (FCW_W, SHIFT_W)
//   - handshake FSM state enum
//   - status_word(): packs the STATUS register
package synth_cfg_pkg;

  localparam int FCW_W   = 24;
  localparam int SHIFT_W = 5;

  localparam int unsigned ADDR_NOTE_EN      = 32'h00;
  localparam int unsigned ADDR_SYNTH_SHIFT  = 32'h01;
  localparam int unsigned ADDR_MOD_FCW      = 32'h02;
  localparam int unsigned ADDR_MOD_SHIFT    = 32'h03;
  localparam int unsigned ADDR_COMMIT       = 32'h04;
  localparam int unsigned ADDR_STATUS       = 32'h05;
  localparam int unsigned ADDR_CARRIER_BASE = 32'h10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } hs_state_e;

  function automatic logic [31:0] status_word(input logic busy, input logic pending);
    return {30'd0, pending, busy};
  endfunction

endpackage

// File: rtl/synth_cfg_ctrl_if.sv
// synth_cfg_ctrl_if: bundles the MMIO port and the CDC-facing snapshot and
// handshake signals of synth_cfg_ctrl.
//   slave  : the controller view (drives rd_data, snapshots, req)
//   master : the environment view (CPU decode and CDC block)
interface synth_cfg_ctrl_if #(
  parameter int N_VOICES = 1,
  parameter int FCW_W    = synth_cfg_pkg::FCW_W,
  parameter int SHIFT_W  = synth_cfg_pkg::SHIFT_W,
  parameter int ADDR_W   = 8
);

  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [31:0]               wr_data;
  logic [ADDR_W-1:0]         rd_addr;
  logic [31:0]               rd_data;

  logic [N_VOICES*FCW_W-1:0] carrier_fcws;
  logic [FCW_W-1:0]          mod_fcw;
  logic [SHIFT_W-1:0]        mod_shift;
  logic [N_VOICES-1:0]       note_en;
  logic [SHIFT_W-1:0]        synth_shift;
  logic                      req;
  logic                      ack;

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, ack,
    output rd_data, carrier_fcws, mod_fcw, mod_shift, note_en, synth_shift, req
  );

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, ack,
    input  rd_data, carrier_fcws, mod_fcw, mod_shift, note_en, synth_shift, req
  );

endinterface

// File: rtl/synth_cfg_handshake.sv
// synth_cfg_handshake: four-phase req/ack sequencer toward the CDC block.
// Holds the commit-pending flag and issues a one-cycle load strobe that tells
// the register file to snapshot its shadows; req rises on the following edge.
//   clk, rst   : clock, asynchronous active-high reset
//   commit_set : request a transfer (sets pending)
//   ack        : CDC acknowledge, already synchronized
//   req        : registered transfer request
//   load       : snapshot strobe (combinational, one cycle)
//   busy       : FSM not in IDLE
//   pending    : a transfer is waiting to start
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no transfer; starts one when pending and ack is low
// REQ      | req high, snapshot stable, waiting for ack to rise
// WAIT_LOW | req low, waiting for ack to fall; chains a pending transfer
module synth_cfg_handshake
  import synth_cfg_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic commit_set,
  input  logic ack,
  output logic req,
  output logic load,
  output logic busy,
  output logic pending
);

  hs_state_e state_q, state_d;
  logic      pending_q, pending_d;
  logic      req_q, req_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      req_q     <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A stale ack (e.g. left high across reset) holds off the transfer.
        if (pending_q && !ack) begin
          load    = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack) state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!ack) begin
          if (pending_q) begin
            load    = 1'b1;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A commit in the same cycle as a load survives, so the follow-up runs.
    pending_d = (pending_q && !load) || commit_set;
    // req comes from its own flop so the CDC never sees decode glitches.
    req_d     = (state_d == REQ);
  end

  assign req     = req_q;
  assign busy    = (state_q != IDLE);
  assign pending = pending_q;

endmodule

// File: rtl/synth_cfg_ctrl.sv
// synth_cfg_ctrl: CPU-side configuration register file for the synthesizer.
// Holds shadow registers written over MMIO, snapshots them into stable output
// registers on commit and hands them to cpu_to_synth_cdc via req/ack.
//   clk  : cpu_clk
//   rst  : asynchronous active-high reset
//   bus  : synth_cfg_ctrl_if.slave
//          wr_en/wr_addr/wr_data : MMIO write, low bits of wr_data used
//          rd_addr/rd_data       : MMIO read, rd_data registered (1 cycle)
//          carrier_fcws, mod_fcw, mod_shift, note_en, synth_shift : snapshots
//          req/ack               : four-phase handshake to the CDC
// Build option: SYNTH_CFG_AUTO_COMMIT_EN makes every shadow write also request
// a transfer; without it only a COMMIT write does.
module synth_cfg_ctrl #(
  parameter int N_VOICES = 1,
  parameter int FCW_W    = synth_cfg_pkg::FCW_W,
  parameter int SHIFT_W  = synth_cfg_pkg::SHIFT_W,
  parameter int ADDR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  synth_cfg_ctrl_if.slave  bus
);
  import synth_cfg_pkg::*;

  localparam int VIDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

  logic [N_VOICES-1:0]             note_en_sh_q, note_en_sh_d;
  logic [SHIFT_W-1:0]              synth_shift_sh_q, synth_shift_sh_d;
  logic [FCW_W-1:0]                mod_fcw_sh_q, mod_fcw_sh_d;
  logic [SHIFT_W-1:0]              mod_shift_sh_q, mod_shift_sh_d;
  logic [N_VOICES-1:0][FCW_W-1:0]  carrier_sh_q, carrier_sh_d;

  logic [N_VOICES-1:0]             note_en_snap_q, note_en_snap_d;
  logic [SHIFT_W-1:0]              synth_shift_snap_q, synth_shift_snap_d;
  logic [FCW_W-1:0]                mod_fcw_snap_q, mod_fcw_snap_d;
  logic [SHIFT_W-1:0]              mod_shift_snap_q, mod_shift_snap_d;
  logic [N_VOICES-1:0][FCW_W-1:0]  carrier_snap_q, carrier_snap_d;

  logic [31:0]       rd_data_q, rd_data_d;

  int unsigned       wa, ra;
  logic              wr_carrier_hit, rd_carrier_hit;
  logic [VIDX_W-1:0] wr_vidx, rd_vidx;
  logic              commit_wr, shadow_wr, commit_set;
  logic              load, busy, pending;
  logic              unused_wr_data_hi;

  assign wa = 32'(bus.wr_addr);
  assign ra = 32'(bus.rd_addr);

  // Carrier registers sit in a window; the offset is only used once the
  // address is known to be inside it.
  assign wr_carrier_hit = (wa >= ADDR_CARRIER_BASE) && (wa < ADDR_CARRIER_BASE + N_VOICES);
  assign rd_carrier_hit = (ra >= ADDR_CARRIER_BASE) && (ra < ADDR_CARRIER_BASE + N_VOICES);
  assign wr_vidx        = VIDX_W'(wa - ADDR_CARRIER_BASE);
  assign rd_vidx        = VIDX_W'(ra - ADDR_CARRIER_BASE);

  assign unused_wr_data_hi = ^bus.wr_data[31:FCW_W];

  always_comb begin
    note_en_sh_d     = note_en_sh_q;
    synth_shift_sh_d = synth_shift_sh_q;
    mod_fcw_sh_d     = mod_fcw_sh_q;
    mod_shift_sh_d   = mod_shift_sh_q;
    carrier_sh_d     = carrier_sh_q;
    commit_wr        = 1'b0;
    shadow_wr        = 1'b0;
    if (bus.wr_en) begin
      if (wa == ADDR_NOTE_EN) begin
        note_en_sh_d = bus.wr_data[N_VOICES-1:0];
        shadow_wr    = 1'b1;
      end else if (wa == ADDR_SYNTH_SHIFT) begin
        synth_shift_sh_d = bus.wr_data[SHIFT_W-1:0];
        shadow_wr        = 1'b1;
      end else if (wa == ADDR_MOD_FCW) begin
        mod_fcw_sh_d = bus.wr_data[FCW_W-1:0];
        shadow_wr    = 1'b1;
      end else if (wa == ADDR_MOD_SHIFT) begin
        mod_shift_sh_d = bus.wr_data[SHIFT_W-1:0];
        shadow_wr      = 1'b1;
      end else if (wa == ADDR_COMMIT) begin
        commit_wr = 1'b1;
      end else if (wr_carrier_hit) begin
        carrier_sh_d[wr_vidx] = bus.wr_data[FCW_W-1:0];
        shadow_wr             = 1'b1;
      end
    end
  end

`ifdef SYNTH_CFG_AUTO_COMMIT_EN
  assign commit_set = commit_wr || shadow_wr;
`else
  assign commit_set = commit_wr;
  logic unused_shadow_wr;
  assign unused_shadow_wr = shadow_wr;
`endif

  synth_cfg_handshake u_handshake (
    .clk        (clk),
    .rst        (rst),
    .commit_set (commit_set),
    .ack        (bus.ack),
    .req        (bus.req),
    .load       (load),
    .busy       (busy),
    .pending    (pending)
  );

  // Snapshots load together with the req rising edge, so they are stable for
  // the whole time req or ack is high.
  always_comb begin
    note_en_snap_d     = note_en_snap_q;
    synth_shift_snap_d = synth_shift_snap_q;
    mod_fcw_snap_d     = mod_fcw_snap_q;
    mod_shift_snap_d   = mod_shift_snap_q;
    carrier_snap_d     = carrier_snap_q;
    if (load) begin
      note_en_snap_d     = note_en_sh_q;
      synth_shift_snap_d = synth_shift_sh_q;
      mod_fcw_snap_d     = mod_fcw_sh_q;
      mod_shift_snap_d   = mod_shift_sh_q;
      carrier_snap_d     = carrier_sh_q;
    end
  end

  always_comb begin
    rd_data_d = 32'd0;
    if (ra == ADDR_NOTE_EN)          rd_data_d = 32'(note_en_sh_q);
    else if (ra == ADDR_SYNTH_SHIFT) rd_data_d = 32'(synth_shift_sh_q);
    else if (ra == ADDR_MOD_FCW)     rd_data_d = 32'(mod_fcw_sh_q);
    else if (ra == ADDR_MOD_SHIFT)   rd_data_d = 32'(mod_shift_sh_q);
    else if (ra == ADDR_STATUS)      rd_data_d = status_word(busy, pending);
    else if (rd_carrier_hit)         rd_data_d = 32'(carrier_sh_q[rd_vidx]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_en_sh_q       <= '0;
      synth_shift_sh_q   <= '0;
      mod_fcw_sh_q       <= '0;
      mod_shift_sh_q     <= '0;
      carrier_sh_q       <= '0;
      note_en_snap_q     <= '0;
      synth_shift_snap_q <= '0;
      mod_fcw_snap_q     <= '0;
      mod_shift_snap_q   <= '0;
      carrier_snap_q     <= '0;
      rd_data_q          <= '0;
    end else begin
      note_en_sh_q       <= note_en_sh_d;
      synth_shift_sh_q   <= synth_shift_sh_d;
      mod_fcw_sh_q       <= mod_fcw_sh_d;
      mod_shift_sh_q     <= mod_shift_sh_d;
      carrier_sh_q       <= carrier_sh_d;
      note_en_snap_q     <= note_en_snap_d;
      synth_shift_snap_q <= synth_shift_snap_d;
      mod_fcw_snap_q     <= mod_fcw_snap_d;
      mod_shift_snap_q   <= mod_shift_snap_d;
      carrier_snap_q     <= carrier_snap_d;
      rd_data_q          <= rd_data_d;
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.carrier_fcws = carrier_snap_q;
  assign bus.mod_fcw      = mod_fcw_snap_q;
  assign bus.mod_shift    = mod_shift_snap_q;
  assign bus.note_en      = note_en_snap_q;
  assign bus.synth_shift  = synth_shift_snap_q;

endmodule
